// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: the debounce FSM state type and the default bus width
// used by both gpio_core and gpio_debouncer.
package gpio_pkg;

    localparam int GPIO_DATA_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_LO,
        WAIT_HI,
        ST_HI,
        WAIT_LO
    } db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: synchronizer chain, qualify-and-accept debounce FSM and
// single-cycle rise/fall pulse registers.
module debounce_bit
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int             CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    db_state_t     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          db_d, rise_d, fall_d;

    // The chain shifts every clock; only the FSM honours sample_tick.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its inputs, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LO;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            db    <= db_d;
            rise  <= rise_d;
            fall  <= fall_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred. Pulse defaults are 0, which
    // also makes them self-clear on untick'd clocks.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        db_d    = db;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample_tick) begin
            unique case (state)
                ST_LO: begin
                    if (s) begin
                        state_d = WAIT_HI;
                        cnt_d   = CW'(1);
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                        db_d    = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                ST_HI: begin
                    if (!s) begin
                        state_d = WAIT_LO;
                        cnt_d   = CW'(1);
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                        db_d    = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gpio_debouncer.sv
// Synchronizes and debounces DATA_WIDTH raw board inputs feeding gpio_core.data_in,
// with per-bit edge pulses and a registered any-event flag.
module gpio_debouncer
    import gpio_pkg::*;
#(
    parameter int DATA_WIDTH    = GPIO_DATA_WIDTH,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic [DATA_WIDTH-1:0] raw_in,
    output logic [DATA_WIDTH-1:0] db_out,
    output logic [DATA_WIDTH-1:0] rise_pulse,
    output logic [DATA_WIDTH-1:0] fall_pulse,
    output logic                  event_any
);

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .sample_tick(sample_tick),
            .raw        (raw_in[g]),
            .db         (db_out[g]),
            .rise       (rise_pulse[g]),
            .fall       (fall_pulse[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) event_any <= 1'b0;
        else       event_any <= |(rise_pulse | fall_pulse);
    end

endmodule

// File: tb/tb_gpio_debouncer.sv
// Bench for gpio_debouncer: directed vector table, hand-written corner sequences
// and randomized stimulus compared against a sample-history reference model.
module tb_gpio_debouncer;

    localparam int W  = 12;
    localparam int SS = 2;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         sample_tick;
    logic [W-1:0] raw_in;
    logic [W-1:0] db_out, rise_pulse, fall_pulse;
    logic         event_any;

    int checks   = 0;
    int failures = 0;

    gpio_debouncer #(
        .DATA_WIDTH   (W),
        .SYNC_STAGES  (SS),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .raw_in     (raw_in),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .event_any  (event_any)
    );

    always #5 clk = ~clk;

    // Reference model: s is raw delayed by SS edges; a bit flips when the last SC
    // ticked samples since reset all disagree with its current debounced level.
    logic [W-1:0] m_sq[$];
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_db, m_rise, m_fall;
    logic         m_ev;

    typedef struct {
        logic [W-1:0] raw;
        logic         tick;
        logic         rst;
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         ev;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [W-1:0] r, input logic t, input logic rs);
        logic [W-1:0] s;
        logic         all_opp;
        if (rs) begin
            m_sq.delete();
            m_hist.delete();
            m_db   = '0;
            m_rise = '0;
            m_fall = '0;
            m_ev   = 1'b0;
        end else begin
            m_ev = |(m_rise | m_fall);
            s    = (m_sq.size() >= SS) ? m_sq[m_sq.size() - SS] : '0;
            m_sq.push_back(r);
            if (m_sq.size() > SS) void'(m_sq.pop_front());
            m_rise = '0;
            m_fall = '0;
            if (t) begin
                m_hist.push_back(s);
                if (m_hist.size() > SC) void'(m_hist.pop_front());
                if (m_hist.size() == SC) begin
                    for (int i = 0; i < W; i++) begin
                        all_opp = 1'b1;
                        foreach (m_hist[k]) if (m_hist[k][i] == m_db[i]) all_opp = 1'b0;
                        if (all_opp) begin
                            m_db[i] = ~m_db[i];
                            if (m_db[i]) m_rise[i] = 1'b1;
                            else         m_fall[i] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    // Drive one clock of stimulus, advance the model, compare just after the edge.
    task automatic step(input logic [W-1:0] r, input logic t, input logic rs);
        raw_in      = r;
        sample_tick = t;
        reset       = rs;
        @(posedge clk);
        model_edge(r, t, rs);
        #1;
        check("model_db",   32'(db_out),     32'(m_db));
        check("model_rise", 32'(rise_pulse), 32'(m_rise));
        check("model_fall", 32'(fall_pulse), 32'(m_fall));
        check("model_ev",   32'(event_any),  32'(m_ev));
    endtask

    // Eight edges of a clean step from old to new level, tick high.
    task automatic add_phase(input logic [W-1:0] old_v, input logic [W-1:0] new_v);
        vec_t v;
        for (int e = 1; e <= 8; e++) begin
            v.raw  = new_v;
            v.tick = 1'b1;
            v.rst  = 1'b0;
            v.db   = (e >= 6) ? new_v : old_v;
            v.rise = (e == 6) ? (new_v & ~old_v) : '0;
            v.fall = (e == 6) ? (old_v & ~new_v) : '0;
            v.ev   = (e == 7) && (old_v != new_v);
            vecs.push_back(v);
        end
    endtask

    initial begin
        vec_t         v;
        logic [W-1:0] r;

        // Reset held with all inputs high: outputs stay zero.
        for (int i = 0; i < 5; i++) begin
            v.raw = 12'hFFF; v.tick = 1'b1; v.rst = 1'b1;
            v.db = '0; v.rise = '0; v.fall = '0; v.ev = 1'b0;
            vecs.push_back(v);
        end
        add_phase(12'h000, 12'hFFF);
        add_phase(12'hFFF, 12'h000);
        add_phase(12'h000, 12'h085);
        add_phase(12'h085, 12'h048);

        foreach (vecs[i]) begin
            step(vecs[i].raw, vecs[i].tick, vecs[i].rst);
            check($sformatf("vec%0d_db", i),   32'(db_out),     32'(vecs[i].db));
            check($sformatf("vec%0d_rise", i), 32'(rise_pulse), 32'(vecs[i].rise));
            check($sformatf("vec%0d_fall", i), 32'(fall_pulse), 32'(vecs[i].fall));
            check($sformatf("vec%0d_ev", i),   32'(event_any),  32'(vecs[i].ev));
        end

        // Bounce on bit 3: toggling is rejected, final stable 1 needs full latency.
        for (int e = 0; e < 8; e++) step(12'h000, 1'b1, 1'b0);
        for (int e = 0; e < 4; e++) begin
            step((e % 2 == 0) ? 12'h008 : 12'h000, 1'b1, 1'b0);
            check("bounce_no_rise", 32'(rise_pulse), 32'h0);
            check("bounce_db_low",  32'(db_out),     32'h0);
        end
        for (int e = 1; e <= 8; e++) begin
            step(12'h008, 1'b1, 1'b0);
            check("bounce_db3",   32'(db_out[3]), (e >= 6) ? 32'h1 : 32'h0);
            check("bounce_rise",  32'(rise_pulse), (e == 6) ? 32'h008 : 32'h0);
        end

        // Reset while bit 0 sits in WAIT_HI with cnt=2.
        for (int e = 0; e < 8; e++) step(12'h000, 1'b1, 1'b0);
        for (int e = 0; e < 4; e++) step(12'h001, 1'b1, 1'b0);
        step(12'h001, 1'b1, 1'b1);
        check("midrst_db",   32'(db_out),     32'h0);
        check("midrst_rise", 32'(rise_pulse), 32'h0);
        for (int e = 1; e <= 8; e++) begin
            step(12'h001, 1'b1, 1'b0);
            check("midrst_relat_db",   32'(db_out),     (e >= 6) ? 32'h001 : 32'h0);
            check("midrst_relat_rise", 32'(rise_pulse), (e == 6) ? 32'h001 : 32'h0);
        end

        // Ticked sampling every 4th clock: s[0]=1 from edge 3, ticks at 4,8,12,16.
        for (int e = 0; e < 8; e++) step(12'h000, 1'b1, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            step(12'h001, (c % 4 == 0), 1'b0);
            check("tick_db0",  32'(db_out[0]),  (c >= 16) ? 32'h1 : 32'h0);
            check("tick_rise", 32'(rise_pulse), (c == 16) ? 32'h001 : 32'h0);
            check("tick_ev",   32'(event_any),  (c == 17) ? 32'h1 : 32'h0);
        end

        // Randomized: slowly wandering bits, bursty ticks, rare resets.
        r = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < W; i++) if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
            step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_debouncer.md
# gpio_debouncer

Input-conditioning stage directly upstream of `gpio_core`'s `data_in` port. It synchronizes `DATA_WIDTH` raw board inputs (switches, buttons) into the `clk` domain and debounces each bit independently. Its `db_out` bus drives `gpio_core.data_in` directly. Single-cycle rise/fall event pulses are also provided for later interrupt or edge-capture logic.

## Interface
- `DATA_WIDTH`, default 12: number of input bits; matches `gpio_core`.
- `SYNC_STAGES`, default 2: synchronizer flops per bit; legal values are ≥2.
- `STABLE_CYCLES`, default 20: consecutive qualifying samples required to accept a new level; legal values are ≥2. Counter width is `$clog2(STABLE_CYCLES+1)`.

Ports (clock and reset first):
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `sample_tick`  in  1  sample enable for the debounce FSMs; tie to 1 for per-clock sampling.
- `raw_in`  in  DATA_WIDTH  asynchronous pin inputs.
- `db_out`  out  DATA_WIDTH  debounced levels; connects to `gpio_core.data_in`.
- `rise_pulse`  out  DATA_WIDTH  per-bit, one cycle high when `db_out` bit goes 0→1.
- `fall_pulse`  out  DATA_WIDTH  per-bit, one cycle high when `db_out` bit goes 1→0.
- `event_any`  out  1  registered OR of all bits of `rise_pulse | fall_pulse`.

## Operation
- **Synchronizer:** the `SYNC_STAGES` chain shifts on every clock, regardless of `sample_tick`. The last stage is `s[i]`.
- **Per-bit FSM:** four states, `ST_LO`, `WAIT_HI`, `ST_HI`, `WAIT_LO`. FSMs evaluate only on edges where `sample_tick=1`; on other edges, state and count hold.
  - `ST_LO`: if `s=1`, go to `WAIT_HI` with `cnt<=1`.
  - `WAIT_HI`: if `s=0`, return to `ST_LO` with `cnt<=0` (bounce rejected). Else if `cnt==STABLE_CYCLES-1`, go to `ST_HI` with `db<=1`, `rise<=1`, `cnt<=0`. Else `cnt++`.
  - `ST_HI` and `WAIT_LO` mirror the above with polarity inverted; the accepting transition drives `fall`.
- `rise_pulse` and `fall_pulse` are registered and deasserted on the next clock, even if `sample_tick` is low.
  - A bit never has rise and fall asserted together.
  - Different bits may pulse in the same cycle.
- `event_any` is asserted one cycle after any pulse bit, for one cycle per pulse cycle.
- **Reset:**
  - All synchronizer flops clear to 0.
  - All FSMs enter `ST_LO` and all counters clear to 0.
  - `db_out`, `rise_pulse`, `fall_pulse` and `event_any` are all 0.
  - An input already high at reset release produces a normal rise after full latency.
- **Reset mid-operation:** any partial count is discarded and no pulse is emitted.

## Timing
- **Latency, tick tied high:** number the first clock edge that samples the new `raw_in` level as edge 1. `db_out` and the pulse update at edge `SYNC_STAGES+STABLE_CYCLES`, provided `raw_in` stays stable.
  - Defaults: 22 cycles.
  - `STABLE_CYCLES=4`: 6 cycles.
- **Latency, ticked:** the transition occurs on the `STABLE_CYCLES`-th `sample_tick` edge at which `s` holds the new value.
- **Pulse width:** exactly 1 clock, independent of tick rate.
- `event_any` lags the pulses by 1 clock.
- Any opposite sample during WAIT restarts qualification from zero; there is no partial credit.
- The counter never exceeds `STABLE_CYCLES-1`, so it never wraps.

## Structure
- Shared package `gpio_pkg`:
  - `typedef enum logic [1:0] {ST_LO, WAIT_HI, ST_HI, WAIT_LO} db_state_t`.
  - Default `DATA_WIDTH` constant, shared with `gpio_core`.
- Sub-module `debounce_bit`: synchronizer, FSM, counter and pulse flops for one bit. The top level instantiates it `DATA_WIDTH` times via `generate` and adds the `event_any` register.

## Test plan
All scenarios use `DATA_WIDTH=12`, `SYNC_STAGES=2`, `STABLE_CYCLES=4` and `sample_tick=1` unless stated otherwise.
- **Reset:** hold `raw_in=0xFFF` with `reset=1` for 5 clocks.
  - During reset, all outputs are 0.
  - After release, `db_out=0xFFF` and `rise_pulse=0xFFF` for one cycle at edge 6.
  - `event_any` goes high at edge 7.
- **Clean step:** `raw_in` changes 0x000→0x085.
  - `db_out=0x085` at edge 6.
  - `rise_pulse=0x085` for exactly 1 cycle; `fall_pulse=0`.
- **Bounce:** bit 3 toggles 1,0,1,0 on successive clocks, then holds 1.
  - No pulse during the toggling.
  - `db_out[3]` rises 6 edges after the final stable 1 is first sampled.
- **Simultaneous rise and fall:** `raw_in` changes 0x085→0x048.
  - At edge 6: `db_out=0x048`, `rise_pulse=0x048`, `fall_pulse=0x085`.
  - `event_any` high for one cycle.
- **Ticked sampling:** `sample_tick` high every 4th clock; `raw_in` changes 0x000→0x001.
  - `db_out[0]` rises on the 4th tick edge with `s[0]=1`.
  - `rise_pulse` is still 1 clock wide.
- **Reset mid-qualification:** bit 0 is in `WAIT_HI` with `cnt=2`; pulse `reset` for 1 clock.
  - `db_out` stays 0 and no pulse is emitted.
  - After release, the full 6-edge latency applies again.
